// File: rtl/vga_monitor_if.sv
// Video output bundle seen at the pixel-clock side of the display path.
//   vga_hs    : horizontal sync, active low
//   vga_vs    : vertical sync, active low
//   vga_blank : high during visible pixels
//   vga_rgb   : pixel colour
// master drives the bundle (controller or generator); slave only observes it.
interface vga_monitor_if;
  logic        vga_hs;
  logic        vga_vs;
  logic        vga_blank;
  logic [23:0] vga_rgb;

  modport master (output vga_hs, output vga_vs, output vga_blank, output vga_rgb);
  modport slave  (input  vga_hs, input  vga_vs, input  vga_blank, input  vga_rgb);
endinterface

// File: rtl/vga_monitor.sv
// Passive checker for the VGA output. Compares sync/blank against a reference raster
// anchored on the vs falling edge, reports lock, sticky errors, clean-frame count and
// a per-frame sum of the active RGB samples. Has no effect on the display path.
//   pixel_clk, pixel_rst_n : clock and asynchronous active-low reset
//   vga                    : observed video bundle (slave modport)
//   clr_err                : clears the sticky error flags
//   locked                 : a full frame matched and checking is still clean
//   err_hsync/vsync/blank  : sticky mismatch flags
//   frame_cnt, frame_sum   : clean frames completed, RGB sum of the last one
//   sum_valid              : one-cycle pulse when frame_sum updates
module vga_monitor #(
  parameter int unsigned HDISP  = 800,
  parameter int unsigned HFP    = 40,
  parameter int unsigned HPULSE = 48,
  parameter int unsigned HBP    = 40,
  parameter int unsigned VDISP  = 480,
  parameter int unsigned VFP    = 13,
  parameter int unsigned VPULSE = 3,
  parameter int unsigned VBP    = 29
) (
  input  logic                pixel_clk,
  input  logic                pixel_rst_n,
  vga_monitor_if.slave        vga,
  input  logic                clr_err,
  output logic                locked,
  output logic                err_hsync,
  output logic                err_vsync,
  output logic                err_blank,
  output logic [15:0]         frame_cnt,
  output logic [31:0]         frame_sum,
  output logic                sum_valid
);

  localparam int unsigned HTOTAL = HPULSE + HBP + HDISP + HFP;
  localparam int unsigned VTOTAL = VPULSE + VBP + VDISP + VFP;
  // One spare value so the active-region end bound always fits.
  localparam int unsigned HW = $clog2(HTOTAL + 1);
  localparam int unsigned VW = $clog2(VTOTAL + 1);

  localparam logic [HW-1:0] HPulseEnd = HW'(HPULSE);
  localparam logic [HW-1:0] HActBeg   = HW'(HPULSE + HBP);
  localparam logic [HW-1:0] HActEnd   = HW'(HPULSE + HBP + HDISP);
  localparam logic [HW-1:0] HLast     = HW'(HTOTAL - 1);
  localparam logic [VW-1:0] VPulseEnd = VW'(VPULSE);
  localparam logic [VW-1:0] VActBeg   = VW'(VPULSE + VBP);
  localparam logic [VW-1:0] VActEnd   = VW'(VPULSE + VBP + VDISP);
  localparam logic [VW-1:0] VLast     = VW'(VTOTAL - 1);

  typedef enum logic [1:0] {StIdle, StCheck, StLocked} state_e;

  state_e        state_q, state_d;
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic          prev_vs_q;
  logic [31:0]   acc_q, acc_d;
  logic          locked_q, locked_d;
  logic [2:0]    err_q, err_d;  // {blank, vsync, hsync}
  logic [15:0]   cnt_q, cnt_d;
  logic [31:0]   sum_q, sum_d;
  logic          sv_q, sv_d;

  logic       vs_fall;
  logic       hs_exp, vs_exp, blank_exp;
  logic       checking;
  logic [2:0] mism;
  logic       frame_end;

  // Reference raster at the current position and per-signal mismatch.
  always_comb begin
    vs_fall   = prev_vs_q & ~vga.vga_vs;
    hs_exp    = ~(h_q < HPulseEnd);
    vs_exp    = ~(v_q < VPulseEnd);
    blank_exp = (h_q >= HActBeg) && (h_q < HActEnd) && (v_q >= VActBeg) && (v_q < VActEnd);
    checking  = (state_q != StIdle);
    mism      = 3'b000;
    if (checking) begin
      mism = {vga.vga_blank ^ blank_exp, vga.vga_vs ^ vs_exp, vga.vga_hs ^ hs_exp};
    end
    frame_end = checking && (mism == 3'b000) && (h_q == HLast) && (v_q == VLast);
  end

  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    v_d     = v_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    sv_d    = 1'b0;
    // A new mismatch overrides a simultaneous clear.
    err_d   = (err_q & ~{3{clr_err}}) | mism;

    unique case (state_q)
      StIdle: begin
        acc_d = '0;
        // The fall sample itself is position (0,0); the next one is (1,0).
        if (vs_fall) begin
          state_d = StCheck;
          h_d     = HW'(1);
          v_d     = '0;
        end
      end
      StCheck, StLocked: begin
        if (mism != 3'b000) begin
          state_d = StIdle;
          acc_d   = '0;
        end else begin
          if (vga.vga_blank) begin
            acc_d = acc_q + {8'h00, vga.vga_rgb};
          end
          if (h_q == HLast) begin
            h_d = '0;
            v_d = (v_q == VLast) ? '0 : v_q + 1'b1;
          end else begin
            h_d = h_q + 1'b1;
          end
          if (frame_end) begin
            state_d = StLocked;
            sum_d   = acc_q;
            sv_d    = 1'b1;
            cnt_d   = cnt_q + 1'b1;
            acc_d   = '0;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    locked_d = (state_d == StLocked);
  end

  always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
    if (!pixel_rst_n) begin
      state_q   <= StIdle;
      h_q       <= '0;
      v_q       <= '0;
      prev_vs_q <= 1'b1;
      acc_q     <= '0;
      locked_q  <= 1'b0;
      err_q     <= '0;
      cnt_q     <= '0;
      sum_q     <= '0;
      sv_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      h_q       <= h_d;
      v_q       <= v_d;
      prev_vs_q <= vga.vga_vs;
      acc_q     <= acc_d;
      locked_q  <= locked_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      sum_q     <= sum_d;
      sv_q      <= sv_d;
    end
  end

  assign locked    = locked_q;
  assign err_hsync = err_q[0];
  assign err_vsync = err_q[1];
  assign err_blank = err_q[2];
  assign frame_cnt = cnt_q;
  assign frame_sum = sum_q;
  assign sum_valid = sv_q;

endmodule

// File: tb/tb_vga_monitor.sv
// Bench for vga_monitor on a reduced raster (15 x 11 = 165 samples per frame).
// The sequencer drives frames and queues the expected output changes; the monitor
// compares them whenever sum_valid pulses or locked / an error flag changes.
module tb_vga_monitor;

  localparam int HDISP = 8, HFP = 2, HPULSE = 3, HBP = 2;
  localparam int VDISP = 6, VFP = 1, VPULSE = 2, VBP = 2;
  localparam int HT = HPULSE + HBP + HDISP + HFP;  // 15
  localparam int VT = VPULSE + VBP + VDISP + VFP;  // 11
  localparam int FR = HT * VT;                     // 165

  logic        pixel_clk = 1'b0;
  logic        pixel_rst_n = 1'b0;
  logic        clr_err = 1'b0;
  logic        locked, err_hsync, err_vsync, err_blank, sum_valid;
  logic [15:0] frame_cnt;
  logic [31:0] frame_sum;

  vga_monitor_if vif ();

  vga_monitor #(
    .HDISP (HDISP), .HFP (HFP), .HPULSE (HPULSE), .HBP (HBP),
    .VDISP (VDISP), .VFP (VFP), .VPULSE (VPULSE), .VBP (VBP)
  ) dut (
    .pixel_clk   (pixel_clk),
    .pixel_rst_n (pixel_rst_n),
    .vga         (vif),
    .clr_err     (clr_err),
    .locked      (locked),
    .err_hsync   (err_hsync),
    .err_vsync   (err_vsync),
    .err_blank   (err_blank),
    .frame_cnt   (frame_cnt),
    .frame_sum   (frame_sum),
    .sum_valid   (sum_valid)
  );

  always #5 pixel_clk = ~pixel_clk;

  int cyc = 0;
  always @(posedge pixel_clk) cyc <= cyc + 1;

  typedef struct {
    int          cycle;
    logic        sv;
    logic        lk;
    logic [2:0]  fl;  // {blank, vsync, hsync}
    logic [31:0] sum;
    logic [15:0] cnt;
  } ev_t;

  ev_t  evq[$];    // expected output changes
  ev_t  snapq[$];  // expected full output state at a given cycle
  logic finish_req = 1'b0;
  int   checks = 0;
  int   failures = 0;

  function automatic ev_t mk(int c, logic sv, logic lk, logic [2:0] fl, logic [31:0] s,
                             logic [15:0] n);
    ev_t e;
    e.cycle = c; e.sv = sv; e.lk = lk; e.fl = fl; e.sum = s; e.cnt = n;
    return e;
  endfunction

  function automatic void push_ev(int c, logic sv, logic lk, logic [2:0] fl, logic [31:0] s,
                                  logic [15:0] n);
    evq.push_back(mk(c, sv, lk, fl, s, n));
  endfunction

  function automatic void push_snap(int c, logic sv, logic lk, logic [2:0] fl, logic [31:0] s,
                                    logic [15:0] n);
    snapq.push_back(mk(c, sv, lk, fl, s, n));
  endfunction

  task automatic drive(input logic hs, input logic vs, input logic bl, input logic [23:0] rgb,
                       input logic clr);
    @(posedge pixel_clk);
    #1;
    vif.vga_hs    = hs;
    vif.vga_vs    = vs;
    vif.vga_blank = bl;
    vif.vga_rgb   = rgb;
    clr_err       = clr;
  endtask

  // kind: 0 ideal, 1 hs high at fidx, 2 blank high at fidx, 3 no vs pulse.
  // clr_err is asserted on sample cidx; only the first nsamp samples are driven.
  task automatic frame(input logic [23:0] rgb, input int kind, input int fidx, input int cidx,
                       input int nsamp);
    for (int v = 0; v < VT; v++) begin
      for (int h = 0; h < HT; h++) begin
        int   idx;
        logic hs, vs, bl;
        idx = v * HT + h;
        hs  = (h >= HPULSE);
        vs  = (v >= VPULSE);
        bl  = (h >= HPULSE + HBP) && (h < HPULSE + HBP + HDISP) &&
              (v >= VPULSE + VBP) && (v < VPULSE + VBP + VDISP);
        if (kind == 1 && idx == fidx) hs = 1'b1;
        if (kind == 2 && idx == fidx) bl = 1'b1;
        if (kind == 3) vs = 1'b1;
        if (idx < nsamp) drive(hs, vs, bl, bl ? rgb : 24'hA5A5A5, idx == cidx);
      end
    end
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
    end
  endtask

  // Monitor / scoreboard.
  initial begin : monitor
    logic [3:0] prev_lf;
    logic [3:0] cur_lf;
    ev_t        e;
    prev_lf = 4'b0000;
    forever begin
      @(negedge pixel_clk);
      while (snapq.size() > 0 && snapq[0].cycle <= cyc) begin
        e = snapq.pop_front();
        cmp("snap_cycle", 32'(cyc), 32'(e.cycle));
        cmp("snap_sum_valid", 32'(sum_valid), 32'(e.sv));
        cmp("snap_locked", 32'(locked), 32'(e.lk));
        cmp("snap_flags", 32'({err_blank, err_vsync, err_hsync}), 32'(e.fl));
        cmp("snap_frame_sum", frame_sum, e.sum);
        cmp("snap_frame_cnt", 32'(frame_cnt), 32'(e.cnt));
      end
      cur_lf = {locked, err_blank, err_vsync, err_hsync};
      if (sum_valid || cur_lf != prev_lf) begin
        if (evq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_event cyc=%0d actual lk/flags=%b sv=%b required none",
                   cyc, cur_lf, sum_valid);
        end else begin
          e = evq.pop_front();
          cmp("ev_cycle", 32'(cyc), 32'(e.cycle));
          cmp("ev_sum_valid", 32'(sum_valid), 32'(e.sv));
          cmp("ev_locked", 32'(locked), 32'(e.lk));
          cmp("ev_flags", 32'({err_blank, err_vsync, err_hsync}), 32'(e.fl));
          cmp("ev_frame_sum", frame_sum, e.sum);
          cmp("ev_frame_cnt", 32'(frame_cnt), 32'(e.cnt));
        end
      end
      prev_lf = cur_lf;
      if (finish_req) begin
        while (evq.size() > 0) begin
          e = evq.pop_front();
          checks++;
          failures++;
          $display("FAIL missing_event actual=none required cycle %0d", e.cycle);
        end
        while (snapq.size() > 0) begin
          e = snapq.pop_front();
          checks++;
          failures++;
          $display("FAIL missing_snap actual=none required cycle %0d", e.cycle);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
      end
    end
  end

  // Sequencer.
  initial begin : sequencer
    int b;
    vif.vga_hs    = 1'b1;
    vif.vga_vs    = 1'b1;
    vif.vga_blank = 1'b0;
    vif.vga_rgb   = 24'h0;
    push_snap(1, 1'b0, 1'b0, 3'b000, 32'd0, 16'd0);
    repeat (3) drive(1'b1, 1'b1, 1'b0, 24'h0, 1'b0);
    pixel_rst_n = 1'b1;
    repeat (4) drive(1'b1, 1'b1, 1'b0, 24'h0, 1'b0);

    // Lock once, then reset mid-frame.
    b = cyc + 1; push_ev(b + FR, 1'b1, 1'b1, 3'b000, 32'd48, 16'd1);
    frame(24'h000001, 0, -1, -1, FR);
    frame(24'h000001, 0, -1, -1, 60);
    push_ev(cyc, 1'b0, 1'b0, 3'b000, 32'd0, 16'd0);
    push_snap(cyc, 1'b0, 1'b0, 3'b000, 32'd0, 16'd0);
    #2 pixel_rst_n = 1'b0;
    repeat (3) drive(1'b1, 1'b1, 1'b0, 24'h0, 1'b0);
    pixel_rst_n = 1'b1;
    for (int i = 0; i < 20; i++) drive(logic'(i % 4 != 0), 1'b1, 1'b0, 24'h123456, 1'b0);
    push_snap(cyc, 1'b0, 1'b0, 3'b000, 32'd0, 16'd0);

    // Three clean frames, rgb = 1.
    b = cyc + 1; push_ev(b + FR, 1'b1, 1'b1, 3'b000, 32'd48, 16'd1);
    frame(24'h000001, 0, -1, -1, FR);
    b = cyc + 1; push_ev(b + FR, 1'b1, 1'b0 | 1'b1, 3'b000, 32'd48, 16'd2);
    frame(24'h000001, 0, -1, -1, FR);
    b = cyc + 1; push_ev(b + FR, 1'b1, 1'b1, 3'b000, 32'd48, 16'd3);
    frame(24'h000001, 0, -1, -1, FR);

    // HS pulse two cycles long on line 5: mismatch at (2,5), index 77.
    b = cyc + 1; push_ev(b + 78, 1'b0, 1'b0, 3'b001, 32'd48, 16'd3);
    frame(24'h000001, 1, 77, -1, FR);
    push_snap(cyc, 1'b0, 1'b0, 3'b001, 32'd48, 16'd3);
    b = cyc + 1; push_ev(b + FR, 1'b1, 1'b1, 3'b001, 32'd96, 16'd4);
    frame(24'h000002, 0, -1, -1, FR);

    // clr_err alone while locked, then blank one extra cycle at (13,6), index 103.
    b = cyc + 1;
    push_ev(b + 11, 1'b0, 1'b1, 3'b000, 32'd96, 16'd4);
    push_ev(b + FR, 1'b1, 1'b1, 3'b000, 32'd144, 16'd5);
    frame(24'h000003, 0, -1, 10, FR);
    b = cyc + 1; push_ev(b + 104, 1'b0, 1'b0, 3'b100, 32'd144, 16'd5);
    frame(24'h000001, 2, 103, -1, FR);
    b = cyc + 1; push_ev(b + FR, 1'b1, 1'b1, 3'b100, 32'd48, 16'd6);
    frame(24'h000001, 0, -1, -1, FR);

    // VS pulse omitted: mismatch at the expected (0,0) sample.
    b = cyc + 1; push_ev(b + 1, 1'b0, 1'b0, 3'b110, 32'd48, 16'd6);
    frame(24'h000001, 3, -1, -1, FR);
    b = cyc + 1; push_ev(b + FR, 1'b1, 1'b1, 3'b110, 32'd48, 16'd7);
    frame(24'h000001, 0, -1, -1, FR);

    // clr_err together with an hs mismatch at (2,3), index 47.
    b = cyc + 1; push_ev(b + 48, 1'b0, 1'b0, 3'b001, 32'd48, 16'd7);
    frame(24'h000001, 1, 47, 47, FR);
    b = cyc + 1;
    push_ev(b + 21, 1'b0, 1'b0, 3'b000, 32'd48, 16'd7);
    push_ev(b + FR, 1'b1, 1'b1, 3'b000, 32'd48, 16'd8);
    frame(24'h000001, 0, -1, 20, FR);
    frame(24'h000001, 0, -1, -1, 5);
    push_snap(cyc, 1'b0, 1'b1, 3'b000, 32'd48, 16'd8);
    drive(vif.vga_hs, vif.vga_vs, vif.vga_blank, vif.vga_rgb, 1'b0);
    finish_req = 1'b1;
  end

endmodule
